// File: rtl/multicycle_control_unit.sv
// Moore-style multicycle control FSM for the 16-bit accumulator/register datapath.
// It sequences fetch/decode/execute, stalls on memory ready and halts on halt, illegal opcode or timeout.
module multicycle_control_unit #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       Halted,
  output logic       Illegal,
  output logic       Timeout,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [2:0]        ALU_ADD    = 3'b000;
  localparam logic [2:0]        ALU_SUB    = 3'b001;

  state_t            state_r;
  state_t            next_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_nxt_s;
  logic              in_mem_s;
  logic              illegal_set_s;
  logic              timeout_set_s;
  logic              fetch_r;
  logic              branch_r;
  logic              jump_r;
  logic              take_branch_s;

  logic [1:0] pcsrc_s;
  logic       iord_s;
  logic       memread_s;
  logic       memwrite_s;
  logic       regwrite_s;
  logic       regdst_s;
  logic       memtoreg_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [2:0] aluop_s;

  // Next-state and wait-counter logic; a stalled memory state either counts or times out.
  always_comb begin
    next_s        = state_r;
    wait_nxt_s    = {WAIT_W{1'b0}};
    illegal_set_s = 1'b0;
    timeout_set_s = 1'b0;
    in_mem_s      = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
    if (in_mem_s && !MemReady) begin
      if (wait_cnt_r == WAIT_LIMIT) begin
        next_s        = S_HALT;
        timeout_set_s = 1'b1;
      end else begin
        wait_nxt_s = wait_cnt_r + WAIT_W'(1);
      end
    end else begin
      case (state_r)
        S_IDLE:     next_s = S_FETCH;
        S_FETCH:    next_s = S_DECODE;
        S_DECODE: begin
          case (Opcode)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: next_s = S_EXEC_R;
            4'h5:                         next_s = S_EXEC_I;
            4'h6, 4'h7:                   next_s = S_MEM_ADDR;
            4'h8, 4'h9:                   next_s = S_BRANCH;
            4'hA:                         next_s = S_JUMP;
            4'hF:                         next_s = S_HALT;
            default: begin
              next_s        = S_HALT;
              illegal_set_s = 1'b1;
            end
          endcase
        end
        S_EXEC_R:   next_s = S_ALU_WB;
        S_EXEC_I:   next_s = S_ALU_WB;
        S_ALU_WB:   next_s = S_FETCH;
        S_MEM_ADDR: begin
          if (Opcode == 4'h6) begin
            next_s = S_MEM_RD;
          end else begin
            next_s = S_MEM_WR;
          end
        end
        S_MEM_RD:   next_s = S_MEM_WB;
        S_MEM_WB:   next_s = S_FETCH;
        S_MEM_WR:   next_s = S_FETCH;
        S_BRANCH:   next_s = S_FETCH;
        S_JUMP:     next_s = S_FETCH;
        S_HALT:     next_s = S_HALT;
        default:    next_s = S_HALT;
      endcase
    end
  end

  // Decode the upcoming state so the Moore outputs leave the flops with the state itself.
  always_comb begin
    pcsrc_s    = 2'b00;
    iord_s     = 1'b0;
    memread_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    regdst_s   = 1'b0;
    memtoreg_s = 1'b0;
    alusrca_s  = 1'b0;
    alusrcb_s  = 2'b00;
    aluop_s    = ALU_ADD;
    case (next_s)
      S_FETCH: begin
        memread_s = 1'b1;
        alusrcb_s = 2'b01;
      end
      S_DECODE:   alusrcb_s = 2'b11;
      S_EXEC_R: begin
        alusrca_s = 1'b1;
        aluop_s   = Opcode[2:0];
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      S_ALU_WB: begin
        regwrite_s = 1'b1;
        regdst_s   = (Opcode <= 4'd4);
      end
      S_MEM_RD: begin
        iord_s    = 1'b1;
        memread_s = 1'b1;
      end
      S_MEM_WB: begin
        regwrite_s = 1'b1;
        memtoreg_s = 1'b1;
      end
      S_MEM_WR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      S_BRANCH: begin
        alusrca_s = 1'b1;
        aluop_s   = ALU_SUB;
        pcsrc_s   = 2'b01;
      end
      S_JUMP:     pcsrc_s = 2'b10;
      default:    pcsrc_s = 2'b00;
    endcase
  end

  // State, wait counter, sticky flags and registered strobes.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= {WAIT_W{1'b0}};
      Illegal    <= 1'b0;
      Timeout    <= 1'b0;
      Halted     <= 1'b0;
      fetch_r    <= 1'b0;
      branch_r   <= 1'b0;
      jump_r     <= 1'b0;
      PCSrc      <= 2'b00;
      IorD       <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      RegWrite   <= 1'b0;
      RegDst     <= 1'b0;
      MemToReg   <= 1'b0;
      ALUSrcA    <= 1'b0;
      ALUSrcB    <= 2'b00;
      ALUOp      <= 3'b000;
    end else begin
      state_r    <= next_s;
      wait_cnt_r <= wait_nxt_s;
      Illegal    <= Illegal | illegal_set_s;
      Timeout    <= Timeout | timeout_set_s;
      Halted     <= (next_s == S_HALT);
      fetch_r    <= (next_s == S_FETCH);
      branch_r   <= (next_s == S_BRANCH);
      jump_r     <= (next_s == S_JUMP);
      PCSrc      <= pcsrc_s;
      IorD       <= iord_s;
      MemRead    <= memread_s;
      MemWrite   <= memwrite_s;
      RegWrite   <= regwrite_s;
      RegDst     <= regdst_s;
      MemToReg   <= memtoreg_s;
      ALUSrcA    <= alusrca_s;
      ALUSrcB    <= alusrcb_s;
      ALUOp      <= aluop_s;
    end
  end

  // Zero and MemReady arrive within the cycle, so these enables cannot wait for a flop.
  assign take_branch_s = ((Opcode == 4'h8) & Zero) | ((Opcode == 4'h9) & ~Zero);
  assign IRWrite       = fetch_r & MemReady;
  assign PCWrite       = (fetch_r & MemReady) | jump_r | (branch_r & take_branch_s);
  assign State         = state_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: an instruction-level model expands each
// opcode and its memory wait plan into the expected per-cycle state and output trace.
module tb_multicycle_control_unit;

  localparam int MAXW = 4;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [3:0] Opcode = 4'h0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemToReg, ALUSrcA;
  logic       Halted, Illegal, Timeout;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUOp;
  logic [3:0] State;

  int   total = 0;
  int   bad = 0;
  int   cur_op = 0;
  logic cur_zero = 1'b0;
  logic illegal_m = 1'b0;
  logic timeout_m = 1'b0;

  multicycle_control_unit #(.MAX_WAIT(MAXW), .WAIT_W(8)) dut (
    .CLK(CLK), .CLR(CLR), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Halted(Halted),
    .Illegal(Illegal), .Timeout(Timeout), .State(State)
  );

  always #5 CLK = ~CLK;

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [18:0] got_outs();
    return {PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemToReg,
            ALUSrcA, ALUSrcB, ALUOp, Halted, Illegal, Timeout};
  endfunction

  // Output table per state number, straight from the control description.
  function automatic logic [18:0] exp_outs(int st, logic rdy, logic z);
    logic pcw, iord, mr, mw, irw, rw, rd, m2r, asa, h;
    logic [1:0] pcs, asb;
    logic [2:0] op3;
    {pcw, iord, mr, mw, irw, rw, rd, m2r, asa, h} = 10'd0;
    pcs = 2'b00; asb = 2'b00; op3 = 3'b000;
    case (st)
      1:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
      2:  asb = 2'b11;
      3:  begin asa = 1'b1; op3 = 3'(cur_op); end
      4:  begin asa = 1'b1; asb = 2'b10; end
      5:  begin rw = 1'b1; rd = (cur_op <= 4); end
      6:  begin asa = 1'b1; asb = 2'b10; end
      7:  begin iord = 1'b1; mr = 1'b1; end
      8:  begin rw = 1'b1; m2r = 1'b1; end
      9:  begin iord = 1'b1; mw = 1'b1; end
      10: begin asa = 1'b1; op3 = 3'b001; pcs = 2'b01;
                pcw = (cur_op == 8 && z) || (cur_op == 9 && !z); end
      11: begin pcs = 2'b10; pcw = 1'b1; end
      12: h = 1'b1;
      default: h = 1'b0;
    endcase
    return {pcw, pcs, iord, mr, mw, irw, rw, rd, m2r, asa, asb, op3, h, illegal_m, timeout_m};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t op=%0d)", tag, got, exp, $time, cur_op);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, then compare state and outputs.
  task automatic step(input int st, input logic rdy);
    logic z;
    @(negedge CLK);
    z = (st == 10) ? cur_zero : rbit();
    Opcode = 4'(cur_op);
    Zero = z;
    MemReady = rdy;
    #1;
    check_val($sformatf("state_in_%0d", st), 32'(State), 32'(st));
    check_val($sformatf("outs_in_%0d", st), 32'(got_outs()), 32'(exp_outs(st, rdy, z)));
  endtask

  task automatic mem_phase(input int st, input int waits, output bit ok);
    int n;
    n = (waits > MAXW) ? MAXW + 1 : waits;
    for (int i = 0; i < n; i++) step(st, 1'b0);
    if (waits > MAXW) begin
      timeout_m = 1'b1;
      ok = 1'b0;
    end else begin
      step(st, 1'b1);
      ok = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    CLR = 1'b0;
    MemReady = rbit();
    #1;
    illegal_m = 1'b0;
    timeout_m = 1'b0;
    check_val("reset_state", 32'(State), 32'd0);
    check_val("reset_outs", 32'(got_outs()), 32'd0);
    repeat (n) @(negedge CLK);
    CLR = 1'b1;
    #1;
    check_val("idle_state", 32'(State), 32'd0);
    check_val("idle_outs", 32'(got_outs()), 32'd0);
  endtask

  // Expand one instruction into its cycle trace; any halt is held, then cleared by reset.
  task automatic run_instr(input int op, input logic z, input int wf, input int wm, input int hn);
    bit ok;
    cur_op = op;
    cur_zero = z;
    mem_phase(1, wf, ok);
    if (ok) begin
      step(2, rbit());
      case (op)
        0, 1, 2, 3, 4: begin step(3, rbit()); step(5, rbit()); end
        5:  begin step(4, rbit()); step(5, rbit()); end
        6:  begin step(6, rbit()); mem_phase(7, wm, ok); if (ok) step(8, rbit()); end
        7:  begin step(6, rbit()); mem_phase(9, wm, ok); end
        8, 9: step(10, rbit());
        10: step(11, rbit());
        15: ok = 1'b0;
        default: begin illegal_m = 1'b1; ok = 1'b0; end
      endcase
    end
    if (!ok) begin
      for (int i = 0; i < hn; i++) step(12, rbit());
      do_reset(2);
    end
  endtask

  initial begin
    bit ok;
    int r, op;
    do_reset(3);
    run_instr(0, 1'b0, 0, 0, 2);
    run_instr(6, 1'b0, 0, 3, 2);
    run_instr(8, 1'b1, 0, 0, 2);
    run_instr(8, 1'b0, 0, 0, 2);
    run_instr(9, 1'b0, 0, 0, 2);
    run_instr(9, 1'b1, 0, 0, 2);
    run_instr(10, 1'b0, 0, 0, 2);
    run_instr(13, 1'b0, 0, 0, 20);
    run_instr(15, 1'b0, 0, 0, 5);
    run_instr(0, 1'b0, MAXW + 1, 0, 3);
    run_instr(7, 1'b0, MAXW, MAXW, 2);
    run_instr(6, 1'b0, 0, MAXW + 1, 2);
    // sw interrupted by reset while MemWrite is held
    cur_op = 7;
    mem_phase(1, 0, ok);
    step(2, rbit());
    step(6, rbit());
    step(9, 1'b0);
    step(9, 1'b0);
    do_reset(1);
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 19);
      op = (r < 17) ? (r % 11) : $urandom_range(11, 15);
      run_instr(op, rbit(),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXW + 1) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, MAXW + 1) : 0,
                $urandom_range(1, 4));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
